// File: rtl/mcs4_bus_master.sv
// MCS-4 bus initiator: generates the two-phase clocks and SYNC, and runs one machine cycle
// per accepted request (address out, opcode capture, X-phase I/O). Bus outputs are registered.
module mcs4_bus_master #(
   parameter int TICK_DIV = 13
) (
   input  logic        sys_clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_kind,
   input  logic [11:0] req_addr,
   input  logic [3:0]  req_cmram,
   input  logic [7:0]  req_data,
   output logic        resp_valid,
   output logic [3:0]  resp_opr,
   output logic [3:0]  resp_opa,
   output logic [3:0]  resp_data,
   output logic        clk1,
   output logic        clk2,
   output logic        sync_n,
   output logic        cmrom_n,
   output logic [3:0]  cmram_n,
   output logic [3:0]  dout_n,
   output logic        doe,
   input  logic [3:0]  din_n
);

   localparam int DW = $clog2(TICK_DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);

   localparam logic [2:0] SC_A1 = 3'd0;
   localparam logic [2:0] SC_A2 = 3'd1;
   localparam logic [2:0] SC_A3 = 3'd2;
   localparam logic [2:0] SC_M1 = 3'd3;
   localparam logic [2:0] SC_M2 = 3'd4;
   localparam logic [2:0] SC_X1 = 3'd5;
   localparam logic [2:0] SC_X2 = 3'd6;
   localparam logic [2:0] SC_X3 = 3'd7;

   localparam logic [1:0] KIND_FETCH = 2'd0;
   localparam logic [1:0] KIND_IO_WR = 2'd1;
   localparam logic [1:0] KIND_IO_RD = 2'd2;
   localparam logic [1:0] KIND_SRC   = 2'd3;

   logic [DW-1:0] div_q;
   logic [2:0]    step_q;
   logic [2:0]    sub_q;
   logic          tick;
   logic          cap_tick;
   logic          cycle_end;

   logic          active_q;
   logic [1:0]    kind_q;
   logic [11:0]   addr_q;
   logic [3:0]    cmram_q;
   logic [7:0]    data_q;
   logic [3:0]    opr_q;
   logic [3:0]    opa_q;

   logic          clk1_d;
   logic          clk2_d;
   logic          sync_d;
   logic          cmrom_d;
   logic [3:0]    cmram_d;
   logic [3:0]    dout_d;
   logic          doe_d;

   assign tick      = (div_q == DIV_MAX);
   assign cap_tick  = tick && (step_q == 3'd5);
   assign cycle_end = tick && (step_q == 3'd6) && (sub_q == SC_X3);
   assign req_ready = cycle_end && req_valid;

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         div_q  <= '0;
         step_q <= 3'd0;
         sub_q  <= SC_X3;
      end else begin
         div_q <= tick ? '0 : div_q + 1'b1;
         if (tick) begin
            if (step_q == 3'd6) begin
               step_q <= 3'd0;
               sub_q  <= sub_q + 3'd1;
            end else begin
               step_q <= step_q + 3'd1;
            end
         end
      end
   end

   // A request is taken only at the very end of X3; an idle cycle still runs clocks and SYNC.
   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         active_q <= 1'b0;
         kind_q   <= KIND_FETCH;
         addr_q   <= '0;
         cmram_q  <= '0;
         data_q   <= '0;
      end else if (cycle_end) begin
         active_q <= req_valid;
         if (req_valid) begin
            kind_q  <= req_kind;
            addr_q  <= req_addr;
            cmram_q <= req_cmram;
            data_q  <= req_data;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         opr_q      <= '0;
         opa_q      <= '0;
         resp_valid <= 1'b0;
         resp_opr   <= '0;
         resp_opa   <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (cap_tick && active_q && sub_q == SC_M1) opr_q <= ~din_n;
         if (cap_tick && active_q && sub_q == SC_M2) opa_q <= ~din_n;
         if (cap_tick && active_q && sub_q == SC_X2 && kind_q != KIND_SRC) begin
            resp_valid <= 1'b1;
            resp_opr   <= opr_q;
            resp_opa   <= opa_q;
            resp_data  <= (kind_q == KIND_IO_RD) ? ~din_n : 4'h0;
         end
         // SRC still drives the bus in X3, so it only completes at the end of the cycle.
         if (cycle_end && active_q && kind_q == KIND_SRC) begin
            resp_valid <= 1'b1;
            resp_opr   <= opr_q;
            resp_opa   <= opa_q;
            resp_data  <= 4'h0;
         end
      end
   end

   always_comb begin
      clk1_d  = !(step_q == 3'd0 || step_q == 3'd1);
      clk2_d  = !(step_q == 3'd4 || step_q == 3'd5);
      sync_d  = (sub_q != SC_X3);
      doe_d   = 1'b0;
      dout_d  = 4'hF;
      cmrom_d = 1'b1;
      cmram_d = 4'hF;
      if (active_q) begin
         case (sub_q)
            SC_A1: begin
               doe_d  = 1'b1;
               dout_d = ~addr_q[3:0];
            end
            SC_A2: begin
               doe_d  = 1'b1;
               dout_d = ~addr_q[7:4];
            end
            SC_A3: begin
               doe_d   = 1'b1;
               dout_d  = ~addr_q[11:8];
               cmrom_d = 1'b0;
               cmram_d = ~cmram_q;
            end
            SC_M2: begin
               if (kind_q == KIND_IO_WR || kind_q == KIND_IO_RD) begin
                  cmrom_d = 1'b0;
                  cmram_d = ~cmram_q;
               end
            end
            SC_X2: begin
               if (kind_q == KIND_IO_WR) begin
                  doe_d  = 1'b1;
                  dout_d = ~data_q[3:0];
               end else if (kind_q == KIND_SRC) begin
                  doe_d   = 1'b1;
                  dout_d  = ~data_q[7:4];
                  cmrom_d = 1'b0;
                  cmram_d = ~cmram_q;
               end
            end
            SC_X3: begin
               if (kind_q == KIND_SRC) begin
                  doe_d  = 1'b1;
                  dout_d = ~data_q[3:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge reset_n) begin
      if (!reset_n) begin
         clk1    <= 1'b1;
         clk2    <= 1'b1;
         sync_n  <= 1'b1;
         cmrom_n <= 1'b1;
         cmram_n <= 4'hF;
         dout_n  <= 4'hF;
         doe     <= 1'b0;
      end else begin
         clk1    <= clk1_d;
         clk2    <= clk2_d;
         sync_n  <= sync_d;
         cmrom_n <= cmrom_d;
         cmram_n <= cmram_d;
         dout_n  <= dout_d;
         doe     <= doe_d;
      end
   end

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Directed bench for mcs4_bus_master: a small responder follows SYNC to feed opcode and
// I/O nibbles, and each task checks bus outputs at fixed points within the machine cycle.
module tb_mcs4_bus_master;

   localparam int TD  = 4;
   localparam int SUB = 7 * TD;
   localparam int CYC = 8 * SUB;
   localparam int PER = 10;

   logic        sys_clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [1:0]  req_kind = 2'd0;
   logic [11:0] req_addr = 12'h0;
   logic [3:0]  req_cmram = 4'h0;
   logic [7:0]  req_data = 8'h0;
   logic        resp_valid;
   logic [3:0]  resp_opr, resp_opa, resp_data;
   logic        clk1, clk2, sync_n, cmrom_n, doe;
   logic [3:0]  cmram_n, dout_n;
   logic [3:0]  din_n = 4'hF;

   int checks = 0;
   int failures = 0;
   int pos = 1000;
   logic prev_sync = 1'b1;
   int resp_cnt = 0;
   logic [3:0] mem_opr = 4'h0, mem_opa = 4'h0, mem_io = 4'h0;

   mcs4_bus_master #(.TICK_DIV(TD)) dut (
      .sys_clk(sys_clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_addr(req_addr), .req_cmram(req_cmram), .req_data(req_data),
      .resp_valid(resp_valid), .resp_opr(resp_opr), .resp_opa(resp_opa),
      .resp_data(resp_data), .clk1(clk1), .clk2(clk2), .sync_n(sync_n),
      .cmrom_n(cmrom_n), .cmram_n(cmram_n), .dout_n(dout_n), .doe(doe),
      .din_n(din_n)
   );

   always #(PER / 2) sys_clk = ~sys_clk;

   // Responder: pos counts clocks since SYNC fell, so pos/SUB is 0=X3,1=A1 .. 7=X2.
   always @(negedge sys_clk) begin
      if (prev_sync && !sync_n) pos = 0;
      else pos = pos + 1;
      prev_sync = sync_n;
      if (resp_valid) resp_cnt = resp_cnt + 1;
      case (pos / SUB)
         4:       din_n = ~mem_opr;
         5:       din_n = ~mem_opa;
         7:       din_n = ~mem_io;
         default: din_n = 4'hF;
      endcase
   end

   task automatic wait_pos(input int p, input string name);
      int n = 0;
      @(negedge sys_clk); #1;
      while (pos != p && n < CYC + 20) begin
         @(negedge sys_clk); #1;
         n++;
      end
      checks++;
      if (pos != p) begin
         failures++;
         $display("[TB] FAIL %s_timeout pos=%0d required=%0d", name, pos, p);
      end
   endtask

   task automatic wait_resp(input int base, input string name);
      int n = 0;
      while (resp_cnt == base && n < 2 * CYC) begin
         @(negedge sys_clk); #1;
         n++;
      end
      checks++;
      if (resp_cnt == base) begin
         failures++;
         $display("[TB] FAIL %s_resp_timeout got=%0d required>%0d", name, resp_cnt, base);
      end
   endtask

   task automatic issue(input logic [1:0] kind, input logic [11:0] addr,
                        input logic [3:0] cm, input logic [7:0] data, input string name);
      int n = 0;
      req_kind = kind; req_addr = addr; req_cmram = cm; req_data = data;
      req_valid = 1'b1;
      @(negedge sys_clk); #1;
      while (!req_ready && n < CYC + 20) begin
         @(negedge sys_clk); #1;
         n++;
      end
      checks++;
      if (!req_ready) begin
         failures++;
         $display("[TB] FAIL %s_ready got=%b required=1", name, req_ready);
      end
      @(posedge sys_clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      int n = 0;
      int low = 0;
      logic [26:0] got;
      reset_n = 1'b0;
      repeat (20) @(posedge sys_clk);
      @(negedge sys_clk); #1;
      got = {clk1, clk2, sync_n, cmrom_n, cmram_n, dout_n, doe, req_ready, resp_valid,
             resp_opr, resp_opa, resp_data};
      checks++;
      if (got !== {4'b1111, 4'hF, 4'hF, 3'b000, 12'h000}) begin
         failures++;
         $display("[TB] FAIL reset_values got=%h required=%h", got,
                  {4'b1111, 4'hF, 4'hF, 3'b000, 12'h000});
      end
      reset_n = 1'b1;
      while (sync_n && n < 50) begin
         @(negedge sys_clk); #1;
         n++;
      end
      while (!sync_n && low < 2 * SUB) begin
         low++;
         @(negedge sys_clk); #1;
      end
      checks++;
      if (low != SUB) begin
         failures++;
         $display("[TB] FAIL reset_sync_len got=%0d required=%0d", low, SUB);
      end
      wait_pos(SUB + 3 * TD, "idle_a1");
      checks++;
      if ({doe, cmrom_n, cmram_n} !== {1'b0, 1'b1, 4'hF}) begin
         failures++;
         $display("[TB] FAIL idle_a1 got=%b required=%b", {doe, cmrom_n, cmram_n}, 6'b011111);
      end
      wait_pos(2 * SUB + TD / 2, "clk_step0");
      checks++;
      if ({clk1, clk2} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL clk_step0 got=%b required=01", {clk1, clk2});
      end
      wait_pos(2 * SUB + 4 * TD + TD / 2, "clk_step4");
      checks++;
      if ({clk1, clk2} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL clk_step4 got=%b required=10", {clk1, clk2});
      end
   endtask

   task automatic test_fetch;
      int r0;
      mem_opr = 4'hD; mem_opa = 4'h5; mem_io = 4'h0;
      r0 = resp_cnt;
      issue(2'd0, 12'hF3A, 4'b0000, 8'h00, "fetch");
      wait_pos(SUB + 3 * TD, "fetch_a1");
      checks++;
      if ({doe, dout_n, cmrom_n} !== {1'b1, 4'h5, 1'b1}) begin
         failures++;
         $display("[TB] FAIL fetch_a1 got=%b required=%b", {doe, dout_n, cmrom_n}, 6'b101011);
      end
      wait_pos(2 * SUB + 3 * TD, "fetch_a2");
      checks++;
      if (dout_n !== 4'hC) begin
         failures++;
         $display("[TB] FAIL fetch_a2_dout got=%h required=c", dout_n);
      end
      wait_pos(3 * SUB + 3 * TD, "fetch_a3");
      checks++;
      if ({dout_n, cmrom_n, cmram_n} !== {4'h0, 1'b0, 4'hF}) begin
         failures++;
         $display("[TB] FAIL fetch_a3 got=%b required=%b", {dout_n, cmrom_n, cmram_n},
                  {4'h0, 1'b0, 4'hF});
      end
      wait_pos(5 * SUB + 3 * TD, "fetch_m2");
      checks++;
      if ({doe, cmrom_n, cmram_n} !== {1'b0, 1'b1, 4'hF}) begin
         failures++;
         $display("[TB] FAIL fetch_m2_cm got=%b required=011111", {doe, cmrom_n, cmram_n});
      end
      wait_resp(r0, "fetch");
      checks++;
      if ({resp_opr, resp_opa, resp_data} !== 12'hD50) begin
         failures++;
         $display("[TB] FAIL fetch_resp got=%h required=d50", {resp_opr, resp_opa, resp_data});
      end
      wait_pos(3 * TD, "fetch_x3");
      checks++;
      if (resp_cnt != r0 + 1) begin
         failures++;
         $display("[TB] FAIL fetch_resp_count got=%0d required=%0d", resp_cnt, r0 + 1);
      end
   endtask

   task automatic test_src;
      int r0;
      mem_opr = 4'h2; mem_opa = 4'h8;
      r0 = resp_cnt;
      issue(2'd3, 12'h000, 4'b0001, 8'h47, "src");
      wait_pos(7 * SUB + 3 * TD, "src_x2");
      checks++;
      if ({doe, dout_n, cmrom_n, cmram_n} !== {1'b1, 4'hB, 1'b0, 4'hE}) begin
         failures++;
         $display("[TB] FAIL src_x2 got=%b required=%b", {doe, dout_n, cmrom_n, cmram_n},
                  {1'b1, 4'hB, 1'b0, 4'hE});
      end
      wait_pos(3 * TD, "src_x3");
      checks++;
      if ({doe, dout_n, cmram_n, resp_cnt == r0} !== {1'b1, 4'h8, 4'hF, 1'b1}) begin
         failures++;
         $display("[TB] FAIL src_x3 got=%b early_resp=%0d required=%b", {doe, dout_n, cmram_n},
                  resp_cnt - r0, {1'b1, 4'h8, 4'hF});
      end
      wait_resp(r0, "src");
      checks++;
      if ({resp_opr, resp_opa, resp_data} !== 12'h280) begin
         failures++;
         $display("[TB] FAIL src_resp got=%h required=280", {resp_opr, resp_opa, resp_data});
      end
   endtask

   task automatic test_io;
      int r0;
      mem_opr = 4'hE; mem_opa = 4'h1; mem_io = 4'h9;
      r0 = resp_cnt;
      issue(2'd2, 12'h000, 4'b0010, 8'h00, "iord");
      wait_pos(5 * SUB + 3 * TD, "iord_m2");
      checks++;
      if ({cmrom_n, cmram_n} !== {1'b0, 4'hD}) begin
         failures++;
         $display("[TB] FAIL iord_m2 got=%b required=%b", {cmrom_n, cmram_n}, {1'b0, 4'hD});
      end
      wait_pos(7 * SUB + 3 * TD, "iord_x2");
      checks++;
      if (doe !== 1'b0) begin
         failures++;
         $display("[TB] FAIL iord_x2_doe got=%b required=0", doe);
      end
      wait_resp(r0, "iord");
      checks++;
      if ({resp_opr, resp_opa, resp_data} !== 12'hE19) begin
         failures++;
         $display("[TB] FAIL iord_resp got=%h required=e19", {resp_opr, resp_opa, resp_data});
      end
      mem_io = 4'h0;
      r0 = resp_cnt;
      issue(2'd1, 12'h000, 4'b0100, 8'h3C, "iowr");
      wait_pos(5 * SUB + 3 * TD, "iowr_m2");
      checks++;
      if ({cmrom_n, cmram_n} !== {1'b0, 4'hB}) begin
         failures++;
         $display("[TB] FAIL iowr_m2 got=%b required=%b", {cmrom_n, cmram_n}, {1'b0, 4'hB});
      end
      wait_pos(7 * SUB + 3 * TD, "iowr_x2");
      checks++;
      if ({doe, dout_n, cmrom_n, cmram_n} !== {1'b1, 4'h3, 1'b1, 4'hF}) begin
         failures++;
         $display("[TB] FAIL iowr_x2 got=%b required=%b", {doe, dout_n, cmrom_n, cmram_n},
                  {1'b1, 4'h3, 1'b1, 4'hF});
      end
      wait_resp(r0, "iowr");
      checks++;
      if (resp_data !== 4'h0) begin
         failures++;
         $display("[TB] FAIL iowr_resp_data got=%h required=0", resp_data);
      end
   endtask

   task automatic test_back_to_back;
      int r0;
      int k = 0;
      int n = 0;
      time t[3];
      mem_opr = 4'h6; mem_opa = 4'hA;
      r0 = resp_cnt;
      req_kind = 2'd0; req_addr = 12'h123; req_cmram = 4'h0; req_data = 8'h00;
      req_valid = 1'b1;
      while (k < 3 && n < 4 * CYC) begin
         @(negedge sys_clk); #1;
         n++;
         if (req_ready) begin
            t[k] = $time;
            k++;
         end
      end
      @(posedge sys_clk); #1;
      req_valid = 1'b0;
      checks++;
      if (k != 3) begin
         failures++;
         $display("[TB] FAIL b2b_ready_count got=%0d required=3", k);
      end else begin
         checks++;
         if ((t[1] - t[0]) != CYC * PER || (t[2] - t[1]) != CYC * PER) begin
            failures++;
            $display("[TB] FAIL b2b_gap got=%0t,%0t required=%0d", t[1] - t[0], t[2] - t[1],
                     CYC * PER);
         end
      end
      n = 0;
      while (resp_cnt < r0 + 3 && n < 2 * CYC) begin
         @(negedge sys_clk); #1;
         n++;
      end
      checks++;
      if (resp_cnt != r0 + 3 || {resp_opr, resp_opa} !== 8'h6A) begin
         failures++;
         $display("[TB] FAIL b2b_resp got=%0d/%h required=%0d/6a", resp_cnt - r0,
                  {resp_opr, resp_opa}, 3);
      end
   endtask

   task automatic test_reset_abort;
      int r0;
      logic [26:0] got;
      mem_opr = 4'h7; mem_opa = 4'h3;
      issue(2'd0, 12'h456, 4'h0, 8'h00, "abort");
      wait_pos(4 * SUB + 3 * TD, "abort_m1");
      r0 = resp_cnt;
      reset_n = 1'b0;
      #2;
      got = {clk1, clk2, sync_n, cmrom_n, cmram_n, dout_n, doe, req_ready, resp_valid,
             resp_opr, resp_opa, resp_data};
      checks++;
      if (got !== {4'b1111, 4'hF, 4'hF, 3'b000, 12'h000}) begin
         failures++;
         $display("[TB] FAIL abort_reset_values got=%h required=%h", got,
                  {4'b1111, 4'hF, 4'hF, 3'b000, 12'h000});
      end
      repeat (5) @(negedge sys_clk);
      reset_n = 1'b1;
      wait_pos(SUB + 3 * TD, "abort_idle_a1");
      checks++;
      if ({doe, cmrom_n} !== 2'b01) begin
         failures++;
         $display("[TB] FAIL abort_idle_a1 got=%b required=01", {doe, cmrom_n});
      end
      wait_pos(3 * TD, "abort_x3");
      checks++;
      if (resp_cnt != r0) begin
         failures++;
         $display("[TB] FAIL abort_no_resp got=%0d required=%0d", resp_cnt, r0);
      end
      mem_opr = 4'h9; mem_opa = 4'hC;
      issue(2'd0, 12'h0A5, 4'h0, 8'h00, "restart");
      wait_pos(SUB + 3 * TD, "restart_a1");
      checks++;
      if ({doe, dout_n} !== {1'b1, 4'hA}) begin
         failures++;
         $display("[TB] FAIL restart_a1 got=%b required=%b", {doe, dout_n}, {1'b1, 4'hA});
      end
      wait_resp(r0, "restart");
      checks++;
      if ({resp_opr, resp_opa, resp_data} !== 12'h9C0) begin
         failures++;
         $display("[TB] FAIL restart_resp got=%h required=9c0", {resp_opr, resp_opa, resp_data});
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_src();
      test_io();
      test_back_to_back();
      test_reset_abort();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
